// File: rtl/bpd_pkg.sv
// Shared definitions for the branch-predictor update scheduler: field widths,
// the packed update-entry layout and the scheduler FSM encoding.
package bpd_pkg;

  localparam int PC_W  = 64;
  localparam int BHR_W = 12;
  localparam int BHT_W = 10;

  // Update-entry bit offsets, LSB first; the struct below follows the same layout.
  localparam int ENT_COND    = 0;
  localparam int ENT_DIR     = 1;
  localparam int ENT_CHBRDIR = 2;
  localparam int ENT_CHWE    = 3;
  localparam int ENT_BHT_LSB = 4;
  localparam int ENT_BHR_LSB = ENT_BHT_LSB + BHT_W;
  localparam int ENT_PC_LSB  = ENT_BHR_LSB + BHR_W;
  localparam int ENT_W       = ENT_PC_LSB + PC_W;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [BHR_W-1:0] bhr;
    logic [BHT_W-1:0] bht;
    logic             chwe;
    logic             chbrdir;
    logic             dir;
    logic             cond;
  } bpd_upd_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bpd_state_e;

  function automatic bpd_upd_t make_upd(
    input logic [PC_W-1:0]  pc,
    input logic [BHR_W-1:0] bhr,
    input logic [BHT_W-1:0] bht,
    input logic             chwe,
    input logic             chbrdir,
    input logic             dir,
    input logic             cond
  );
    bpd_upd_t e;
    e.pc      = pc;
    e.bhr     = bhr;
    e.bht     = bht;
    e.chwe    = chwe;
    e.chbrdir = chbrdir;
    e.dir     = dir;
    e.cond    = cond;
    return e;
  endfunction

endpackage

// File: rtl/bpd_upd_fifo.sv
// In-order update queue: up to two pushes and one pop per cycle, with a sticky
// overflow flag for pushes that arrive while the queue had no room for two.
module bpd_upd_fifo
  import bpd_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push0_vld,
  input  bpd_upd_t         push0_data,
  input  logic             push1_vld,
  input  bpd_upd_t         push1_data,
  input  logic             pop,
  output bpd_upd_t         head_data,
  output logic [CNT_W-1:0] count,
  output logic             rdy,
  output logic             ovf_err
);

  localparam logic [CNT_W:0]   DEPTH_X   = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] RDY_LIMIT = CNT_W'(DEPTH - 2);

  bpd_upd_t         mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] wr1_ptr;
  logic [CNT_W:0]   avail;
  logic             pop_eff;
  logic             acc0;
  logic             acc1;
  logic             drop;
  logic [1:0]       n_acc;

  assign pop_eff = pop && (count != '0);
  // The slot freed by a same-cycle pop counts as space for a push.
  assign avail   = DEPTH_X - {1'b0, count} + {{CNT_W{1'b0}}, pop_eff};
  assign acc0    = push0_vld && !flush && (avail != '0);
  assign acc1    = push1_vld && !flush &&
                   (push0_vld ? (avail >= (CNT_W + 1)'(2)) : (avail != '0));
  assign wr1_ptr = acc0 ? tail + PTR_W'(1) : tail;
  assign n_acc   = {1'b0, acc0} + {1'b0, acc1};
  assign drop    = (push0_vld && !acc0) || (push1_vld && !acc1);

  assign head_data = mem[head];
  assign rdy       = (count <= RDY_LIMIT);

  always_ff @(posedge clock) begin
    if (acc0) mem[tail] <= push0_data;
    if (acc1) mem[wr1_ptr] <= push1_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      ovf_err <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(pop_eff);
      tail  <= tail + PTR_W'(n_acc);
      count <= count + CNT_W'(n_acc) - CNT_W'(pop_eff);
      if (((push0_vld || push1_vld) && !rdy) || drop) ovf_err <= 1'b1;
    end
  end

endmodule

// File: rtl/bpd_upd_sched.sv
// Retire-to-predictor update scheduler: queues branch outcomes, drains them one per
// cycle into the shared predictor write port, and runs the table-init sweep.
module bpd_upd_sched
  import bpd_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int IDX_W    = 12,
  parameter int INIT_CNT = 4096
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             rt0_vld_i,
  input  logic [PC_W-1:0]  rt0_pc_i,
  input  logic [BHR_W-1:0] rt0_bhr_i,
  input  logic [BHT_W-1:0] rt0_bht_i,
  input  logic             rt0_chwe_i,
  input  logic             rt0_chbrdir_i,
  input  logic             rt0_dir_i,
  input  logic             rt0_cond_i,
  input  logic             rt1_vld_i,
  input  logic [PC_W-1:0]  rt1_pc_i,
  input  logic [BHR_W-1:0] rt1_bhr_i,
  input  logic [BHT_W-1:0] rt1_bht_i,
  input  logic             rt1_chwe_i,
  input  logic             rt1_chbrdir_i,
  input  logic             rt1_dir_i,
  input  logic             rt1_cond_i,
  input  logic             init_req_i,
  input  logic             bpd_wr_block_i,
  output logic             upd_rdy_o,
  output logic             upd_vld_o,
  output logic [PC_W-1:0]  upd_pc_o,
  output logic [BHR_W-1:0] upd_bhr_o,
  output logic [BHT_W-1:0] upd_bht_o,
  output logic             upd_chwe_o,
  output logic             upd_chbrdir_o,
  output logic             upd_dir_o,
  output logic             upd_brcond_o,
  output logic             upd_brindir_o,
  output logic             init_we_o,
  output logic [IDX_W-1:0] init_idx_o,
  output logic             init_busy_o,
  output logic             ovf_err_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INIT_CNT - 1);

  bpd_state_e       state;
  bpd_upd_t         push0;
  bpd_upd_t         push1;
  bpd_upd_t         head;
  logic [CNT_W-1:0] count;
  logic             flush;

  assign push0 = make_upd(rt0_pc_i, rt0_bhr_i, rt0_bht_i, rt0_chwe_i,
                          rt0_chbrdir_i, rt0_dir_i, rt0_cond_i);
  assign push1 = make_upd(rt1_pc_i, rt1_bhr_i, rt1_bht_i, rt1_chwe_i,
                          rt1_chbrdir_i, rt1_dir_i, rt1_cond_i);

  // Re-init from RUN discards queued and same-cycle updates; tables are being wiped.
  assign flush     = init_req_i && (state == ST_RUN);
  assign upd_vld_o = (state == ST_RUN) && (count != '0) && !bpd_wr_block_i;

  bpd_upd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (flush),
    .push0_vld  (rt0_vld_i),
    .push0_data (push0),
    .push1_vld  (rt1_vld_i),
    .push1_data (push1),
    .pop        (upd_vld_o),
    .head_data  (head),
    .count      (count),
    .rdy        (upd_rdy_o),
    .ovf_err    (ovf_err_o)
  );

  assign upd_pc_o      = head.pc;
  assign upd_bhr_o     = head.bhr;
  assign upd_bht_o     = head.bht;
  assign upd_chwe_o    = head.chwe;
  assign upd_chbrdir_o = head.chbrdir;
  assign upd_dir_o     = head.dir;
  assign upd_brcond_o  = upd_vld_o && head.cond;
  assign upd_brindir_o = upd_vld_o && !head.cond;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_INIT;
      init_idx_o  <= '0;
      init_we_o   <= 1'b1;
      init_busy_o <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_req_i) begin
            init_idx_o <= '0;
          end else if (init_idx_o == IDX_LAST) begin
            state       <= ST_RUN;
            init_idx_o  <= '0;
            init_we_o   <= 1'b0;
            init_busy_o <= 1'b0;
          end else begin
            init_idx_o <= init_idx_o + IDX_W'(1);
          end
        end
        ST_RUN: begin
          if (init_req_i) begin
            state       <= ST_INIT;
            init_idx_o  <= '0;
            init_we_o   <= 1'b1;
            init_busy_o <= 1'b1;
          end
        end
        default: begin
          state       <= ST_INIT;
          init_idx_o  <= '0;
          init_we_o   <= 1'b1;
          init_busy_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bpd_upd_sched.sv
// Scoreboard bench for bpd_upd_sched: directed pushes queue expected updates, a
// negedge monitor pops and compares every update the DUT presents.
module tb_bpd_upd_sched;

  logic        clock;
  logic        reset_n;
  logic        rt0_vld_i, rt1_vld_i;
  logic [63:0] rt0_pc_i, rt1_pc_i;
  logic [11:0] rt0_bhr_i, rt1_bhr_i;
  logic [9:0]  rt0_bht_i, rt1_bht_i;
  logic        rt0_chwe_i, rt1_chwe_i;
  logic        rt0_chbrdir_i, rt1_chbrdir_i;
  logic        rt0_dir_i, rt1_dir_i;
  logic        rt0_cond_i, rt1_cond_i;
  logic        init_req_i;
  logic        bpd_wr_block_i;
  logic        upd_rdy_o, upd_vld_o;
  logic [63:0] upd_pc_o;
  logic [11:0] upd_bhr_o;
  logic [9:0]  upd_bht_o;
  logic        upd_chwe_o, upd_chbrdir_o, upd_dir_o;
  logic        upd_brcond_o, upd_brindir_o;
  logic        init_we_o;
  logic [11:0] init_idx_o;
  logic        init_busy_o;
  logic        ovf_err_o;

  typedef struct {
    logic [63:0] pc;
    logic        dir;
    logic        cond;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  bpd_upd_sched #(.DEPTH(8), .IDX_W(12), .INIT_CNT(4096)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .rt0_vld_i      (rt0_vld_i),
    .rt0_pc_i       (rt0_pc_i),
    .rt0_bhr_i      (rt0_bhr_i),
    .rt0_bht_i      (rt0_bht_i),
    .rt0_chwe_i     (rt0_chwe_i),
    .rt0_chbrdir_i  (rt0_chbrdir_i),
    .rt0_dir_i      (rt0_dir_i),
    .rt0_cond_i     (rt0_cond_i),
    .rt1_vld_i      (rt1_vld_i),
    .rt1_pc_i       (rt1_pc_i),
    .rt1_bhr_i      (rt1_bhr_i),
    .rt1_bht_i      (rt1_bht_i),
    .rt1_chwe_i     (rt1_chwe_i),
    .rt1_chbrdir_i  (rt1_chbrdir_i),
    .rt1_dir_i      (rt1_dir_i),
    .rt1_cond_i     (rt1_cond_i),
    .init_req_i     (init_req_i),
    .bpd_wr_block_i (bpd_wr_block_i),
    .upd_rdy_o      (upd_rdy_o),
    .upd_vld_o      (upd_vld_o),
    .upd_pc_o       (upd_pc_o),
    .upd_bhr_o      (upd_bhr_o),
    .upd_bht_o      (upd_bht_o),
    .upd_chwe_o     (upd_chwe_o),
    .upd_chbrdir_o  (upd_chbrdir_o),
    .upd_dir_o      (upd_dir_o),
    .upd_brcond_o   (upd_brcond_o),
    .upd_brindir_o  (upd_brindir_o),
    .init_we_o      (init_we_o),
    .init_idx_o     (init_idx_o),
    .init_busy_o    (init_busy_o),
    .ovf_err_o      (ovf_err_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // History/choice side fields are derived from the PC so each entry is distinct.
  task automatic drive(input logic v0, input logic [63:0] p0, input logic d0, input logic c0,
                       input logic v1, input logic [63:0] p1, input logic d1, input logic c1);
    rt0_vld_i = v0; rt0_pc_i = p0; rt0_bhr_i = p0[15:4]; rt0_bht_i = p0[13:4];
    rt0_chwe_i = p0[4]; rt0_chbrdir_i = p0[5]; rt0_dir_i = d0; rt0_cond_i = c0;
    rt1_vld_i = v1; rt1_pc_i = p1; rt1_bhr_i = p1[15:4]; rt1_bht_i = p1[13:4];
    rt1_chwe_i = p1[4]; rt1_chbrdir_i = p1[5]; rt1_dir_i = d1; rt1_cond_i = c1;
  endtask

  task automatic idle();
    drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
  endtask

  task automatic expect_upd(input logic [63:0] pc, input logic dir, input logic cond);
    exp_t e;
    e.pc = pc; e.dir = dir; e.cond = cond;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: every presented update must match the oldest expected entry.
  always @(negedge clock) begin
    if (reset_n && upd_vld_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_upd", upd_pc_o, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("upd_pc", upd_pc_o, e.pc);
        chk("upd_fields",
            {40'h0, upd_bhr_o, upd_bht_o, upd_chwe_o, upd_chbrdir_o, upd_dir_o,
             upd_brcond_o, upd_brindir_o},
            {40'h0, e.pc[15:4], e.pc[13:4], e.pc[4], e.pc[5], e.dir, e.cond, ~e.cond});
      end
    end
  end

  initial begin
    int bad;
    int pairs;
    int drained;

    reset_n = 1'b0;
    init_req_i = 1'b0;
    bpd_wr_block_i = 1'b0;
    idle();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_idx", 64'(init_idx_o), 64'h0);
    chk("rst_we_busy", {62'h0, init_we_o, init_busy_o}, 64'h3);
    chk("rst_rdy_vld_ovf", {61'h0, upd_rdy_o, upd_vld_o, ovf_err_o}, 64'h4);

    // First sweep; two updates are queued mid-sweep and must wait for RUN.
    reset_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 4096; c++) begin
      if (c > 0) step();
      if (c == 100) begin
        drive(1'b1, 64'hA0, 1'b1, 1'b1, 1'b1, 64'hB0, 1'b0, 1'b0);
        expect_upd(64'hA0, 1'b1, 1'b1);
        expect_upd(64'hB0, 1'b0, 1'b0);
      end else begin
        idle();
      end
      @(negedge clock);
      if (init_idx_o != 12'(c) || !init_we_o || !init_busy_o ||
          upd_vld_o || upd_brcond_o || upd_brindir_o) bad++;
    end
    chk("sweep1_bad_cycles", 64'(bad), 64'h0);

    step();
    @(negedge clock);
    chk("run_we_busy", {62'h0, init_we_o, init_busy_o}, 64'h0);
    chk("run0_head", {upd_pc_o[62:0], upd_vld_o}, {63'hA0, 1'b1});
    step();
    @(negedge clock);
    chk("run1_head", {upd_pc_o[62:0], upd_vld_o}, {63'hB0, 1'b1});
    step();
    @(negedge clock);
    chk("run2_empty", 64'(upd_vld_o), 64'h0);

    // Dual push: older slot first, one per cycle.
    step();
    drive(1'b1, 64'h1000, 1'b1, 1'b1, 1'b1, 64'h2000, 1'b0, 1'b0);
    expect_upd(64'h1000, 1'b1, 1'b1);
    expect_upd(64'h2000, 1'b0, 1'b0);
    @(negedge clock);
    chk("pair_no_same_cycle", 64'(upd_vld_o), 64'h0);
    step();
    idle();
    @(negedge clock);
    chk("pair_first", {upd_pc_o[59:0], upd_vld_o, upd_brcond_o, upd_brindir_o, 1'b0},
        {60'h1000, 1'b1, 1'b1, 1'b0, 1'b0});
    step();
    @(negedge clock);
    chk("pair_second", {upd_pc_o[59:0], upd_vld_o, upd_brcond_o, upd_brindir_o, upd_dir_o},
        {60'h2000, 1'b1, 1'b0, 1'b1, 1'b0});
    step();

    // Blocked write port: fill while ready, then drain exactly 8.
    pairs = 0;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      bpd_wr_block_i = 1'b1;
      if (upd_rdy_o) begin
        drive(1'b1, 64'h3000 + 64'(k * 32), 1'b0, 1'b1,
              1'b1, 64'h3010 + 64'(k * 32), 1'b1, 1'b0);
        expect_upd(64'h3000 + 64'(k * 32), 1'b0, 1'b1);
        expect_upd(64'h3010 + 64'(k * 32), 1'b1, 1'b0);
        pairs++;
      end else begin
        idle();
      end
      @(negedge clock);
      if (upd_vld_o) bad++;
    end
    chk("blocked_pairs_accepted", 64'(pairs), 64'h4);
    chk("blocked_no_vld", 64'(bad), 64'h0);
    step();
    idle();
    @(negedge clock);
    chk("full_rdy_ovf", {62'h0, upd_rdy_o, ovf_err_o}, 64'h0);
    step();
    bpd_wr_block_i = 1'b0;
    drained = 0;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) step();
      @(negedge clock);
      if (upd_vld_o) drained++;
    end
    chk("drained_8", 64'(drained), 64'h8);
    step();
    @(negedge clock);
    chk("drain_done", {62'h0, upd_vld_o, upd_rdy_o}, 64'h1);

    // Overflow: reach 7 entries, then a dual push keeps only the older one.
    for (int k = 0; k < 4; k++) begin
      step();
      bpd_wr_block_i = 1'b1;
      drive(1'b1, 64'h4000 + 64'(k * 32), 1'b1, 1'b1,
            k < 3, 64'h4010 + 64'(k * 32), 1'b0, 1'b0);
      expect_upd(64'h4000 + 64'(k * 32), 1'b1, 1'b1);
      if (k < 3) expect_upd(64'h4010 + 64'(k * 32), 1'b0, 1'b0);
    end
    step();
    chk("cnt7_rdy_low", 64'(upd_rdy_o), 64'h0);
    drive(1'b1, 64'h4F00, 1'b0, 1'b1, 1'b1, 64'h4F10, 1'b1, 1'b0);
    expect_upd(64'h4F00, 1'b0, 1'b1);
    step();
    idle();
    @(negedge clock);
    chk("ovf_set", {62'h0, ovf_err_o, upd_rdy_o}, 64'h2);
    step();
    bpd_wr_block_i = 1'b0;
    drained = 0;
    for (int j = 0; j < 10; j++) begin
      if (j > 0) step();
      @(negedge clock);
      if (upd_vld_o) drained++;
    end
    chk("ovf_drained_8", 64'(drained), 64'h8);
    chk("ovf_sticky", 64'(ovf_err_o), 64'h1);

    // Re-init from RUN with 3 queued entries: all discarded.
    step();
    bpd_wr_block_i = 1'b1;
    drive(1'b1, 64'h5000, 1'b1, 1'b1, 1'b1, 64'h5010, 1'b1, 1'b1);
    step();
    drive(1'b1, 64'h5020, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    step();
    idle();
    @(negedge clock);
    chk("held_no_vld", 64'(upd_vld_o), 64'h0);
    step();
    init_req_i = 1'b1;
    drive(1'b1, 64'h5030, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    step();
    init_req_i = 1'b0;
    bpd_wr_block_i = 1'b0;
    idle();
    @(negedge clock);
    chk("reinit_state", {48'h0, init_idx_o, init_we_o, init_busy_o, upd_vld_o, upd_rdy_o},
        {48'h0, 12'h000, 1'b1, 1'b1, 1'b0, 1'b1});
    bad = 0;
    for (int c = 1; c < 4096; c++) begin
      step();
      @(negedge clock);
      if (init_idx_o != 12'(c) || !init_busy_o || upd_vld_o) bad++;
    end
    chk("sweep2_bad_cycles", 64'(bad), 64'h0);
    step();
    @(negedge clock);
    chk("reinit_run_empty", {61'h0, init_busy_o, upd_vld_o, ovf_err_o}, 64'h1);
    chk("scoreboard_empty", 64'(sb.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bpd_upd_sched.md
Name: bpd_upd_sched

Overview:
- Sits between the retire stage and the tournament branch predictor's write ports.
- Buffers up to two certified branch-outcome updates per cycle in an in-order queue.
- Drains the queue at one update per cycle into the single non-speculative write port shared by the choice PHT, BHT, global PHT and local PHT.
- Owns the predictor-table initialisation sweep after reset or on request.

Parameters:
- DEPTH, 8, update-queue entries; power of two, at least 4.
- IDX_W, 12, sweep index width; covers the largest table (4096 entries).
- INIT_CNT, 4096, number of sweep cycles.

Ports:
- clock  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- rt0_vld_i  in  1  retire slot 0 branch update valid (older slot)
- rt0_pc_i  in  64  slot 0 branch PC
- rt0_bhr_i  in  12  slot 0 global history snapshot
- rt0_bht_i  in  10  slot 0 local history snapshot
- rt0_chwe_i  in  1  slot 0 choice-update enable
- rt0_chbrdir_i  in  1  slot 0 choice local-prediction bit
- rt0_dir_i  in  1  slot 0 resolved direction
- rt0_cond_i  in  1  slot 0 type: 1 = conditional, 0 = indirect
- rt1_*  in  same  retire slot 1 (younger), same fields as slot 0
- init_req_i  in  1  pulse: re-initialise all predictor tables
- bpd_wr_block_i  in  1  predictor write port unavailable this cycle
- upd_rdy_o  out  1  queue can accept two pushes next cycle
- upd_vld_o  out  1  update presented to predictor this cycle
- upd_pc_o  out  64  head entry PC
- upd_bhr_o  out  12  head entry global history
- upd_bht_o  out  10  head entry local history
- upd_chwe_o  out  1  head entry choice-update enable
- upd_chbrdir_o  out  1  head entry choice local-prediction bit
- upd_dir_o  out  1  head entry direction
- upd_brcond_o  out  1  upd_vld_o & cond
- upd_brindir_o  out  1  upd_vld_o & ~cond
- init_we_o  out  1  sweep write strobe
- init_idx_o  out  IDX_W  sweep index
- init_busy_o  out  1  sweep in progress
- ovf_err_o  out  1  sticky overflow error

Behaviour:
- Reset values: state INIT; queue empty (count 0); init_idx_o 0; ovf_err_o 0; upd_rdy_o 1; upd_vld_o 0; init_we_o 1; init_busy_o 1.
- FSM has two states: INIT and RUN.
- INIT:
  - init_we_o = 1 and init_busy_o = 1.
  - init_idx_o increments by 1 per cycle.
  - When init_idx_o = INIT_CNT-1, next state is RUN and the index returns to 0. The sweep therefore lasts exactly INIT_CNT cycles.
  - Tables consume the low bits of init_idx_o: all 12 for the 4096-entry PHTs, low 10 for the BHT and local PHT.
- RUN: init_we_o = 0 and init_busy_o = 0.
- init_req_i in RUN:
  - Next state INIT, index 0.
  - Queue is emptied; pending and same-cycle pushes are discarded because the tables are being reinitialised.
- init_req_i in INIT: index restarts at 0 and the queue is preserved.
- Queue:
  - Circular buffer of 90-bit entries with head pointer, tail pointer and count of width log2(DEPTH)+1.
  - Pushes:
    - rt0 only: one entry.
    - rt1 only: one entry.
    - Both valid: rt0 at tail, rt1 at tail+1; count += 2.
  - Pointers wrap modulo DEPTH.
- Pushes are accepted in both INIT and RUN.
- upd_rdy_o = (count <= DEPTH-2), taken from the registered count.
- Pushing when upd_rdy_o was 0 in the previous cycle is a protocol error:
  - Any push that would exceed DEPTH is dropped.
  - ovf_err_o is set and stays set until reset.
- Drain:
  - upd_vld_o = (state == RUN) & (count != 0) & ~bpd_wr_block_i.
  - Head fields are read combinationally from storage.
  - The head pops on the same cycle upd_vld_o is high.
- Latency: an entry pushed in cycle N can appear on upd_vld_o in cycle N+1 at the earliest.
- Simultaneous pop and push is allowed in the same cycle: new count = count + pushes − pop.
- When upd_vld_o is 0, the upd_* data outputs hold head contents (don't-care). upd_brcond_o and upd_brindir_o are 0.
- Asynchronous reset mid-sweep or mid-drain returns to the reset state immediately; the queue is lost.

Decomposition:
- Shared package bpd_pkg holds:
  - BHR_W = 12, BHT_W = 10, PC_W = 64;
  - the update-entry field offsets and width (90);
  - the FSM state encoding for INIT and RUN.
- One natural sub-module: bpd_upd_fifo, a 2-push / 1-pop circular queue with count.
- The FSM and sweep counter live in bpd_upd_sched.

Test Plan:
- Reset release -> init_we_o = 1 for exactly 4096 cycles with init_idx_o 0..4095, upd_vld_o = 0 throughout; cycle 4096 init_busy_o = 0.
- RUN, one cycle of rt0 (pc 0x1000, dir 1, cond 1) plus rt1 (pc 0x2000, dir 0, cond 0) -> cycle+1: upd_pc_o 0x1000, upd_brcond_o = 1; cycle+2: upd_pc_o 0x2000, upd_brindir_o = 1, upd_dir_o = 0.
- Hold bpd_wr_block_i = 1 while pushing 2 entries per cycle -> upd_rdy_o drops once count reaches 7; after unblocking, exactly 8 entries drain in order, one per cycle, with no loss.
- With count = 7, push two more -> count = 8, the excess push is dropped, ovf_err_o = 1 and stays 1.
- RUN with 3 queued entries, pulse init_req_i -> next cycle init_busy_o = 1, count = 0, sweep restarts at index 0; no upd_vld_o for 4096 cycles.
- During INIT, push 2 entries -> upd_vld_o stays 0; both entries drain in order on the first two RUN cycles.
